// File: rtl/mem_access_bridge.sv
// mem_access_bridge: MEM-stage data-bus master that stalls the pipeline until a load/store completes on the bus
module mem_access_bridge #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_i,
  input  logic [3:0]  memwrite_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  input  logic        pipe_stall_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        bus_err_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [3:0]  data_wstrb_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic wr_q, cancel_q, launch, busy, tmo, fin, cancel;
  logic [1:0] size_q, size_m;
  logic [3:0] strb_q;
  logic [31:0] addr_q, wdata_q, rdata_q, wrep;
  always_comb begin
    size_m = size_i == 2'd3 ? 2'd2 : size_i;
    wrep = size_m == 2'd0 ? {4{wdata_i[7:0]}} : size_m == 2'd1 ? {2{wdata_i[15:0]}} : wdata_i;
    launch = state == IDLE && mem_en_i && !flush_i;
    busy = state == REQ || state == WAIT;
    tmo = busy && cnt == CW'(TIMEOUT_CYC);
    fin = !tmo && data_data_ok_i && (state == WAIT || (state == REQ && data_addr_ok_i));
    cancel = cancel_q || flush_i;
    state_n = state;
    case (state)
      IDLE: if (launch) state_n = REQ;
      REQ, WAIT:
        if (tmo || (fin && cancel)) state_n = IDLE;
        else if (fin) state_n = DONE;
        else if (state == REQ && data_addr_ok_i) state_n = WAIT;
      DONE: if (flush_i || !pipe_stall_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    stall_o = launch || busy;
    data_req_o = state == REQ && !tmo;
    rdata_valid_o = state == DONE && !wr_q;
    bus_err_o = tmo;
    rdata_o = rdata_q;
    data_wr_o = wr_q;
    data_size_o = size_q;
    data_wstrb_o = strb_q;
    data_addr_o = addr_q;
    data_wdata_o = wdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cancel_q <= 1'b0;
      wr_q <= 1'b0;
      size_q <= '0;
      strb_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        wr_q <= |memwrite_i;
        size_q <= size_m;
        strb_q <= memwrite_i;
        addr_q <= addr_i;
        wdata_q <= wrep;
        cnt <= '0;
        cancel_q <= 1'b0;
      end
      if (busy) begin
        cnt <= cnt + CW'(1);
        cancel_q <= cancel && state_n != IDLE;
      end
      if (fin && !cancel && !wr_q) rdata_q <= data_rdata_i;
    end
  end
endmodule

// File: tb/tb_mem_access_bridge.sv
// tb_mem_access_bridge: vector table, corner-case sequences and randomized transactions against a bus-level model
module tb_mem_access_bridge;
  logic clk = 1'b0, rst;
  logic mem_en, flush, pipe_stall, addr_ok, data_ok;
  logic [3:0] memwrite;
  logic [1:0] size;
  logic [31:0] addr, wdata, rdata;
  logic stall, rvalid, bus_err, req, wr;
  logic [1:0] bsize;
  logic [3:0] wstrb;
  logic [31:0] rdata_q, baddr, bwdata;
  int checks = 0, errors = 0;
  mem_access_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .mem_en_i(mem_en), .memwrite_i(memwrite), .size_i(size),
    .addr_i(addr), .wdata_i(wdata), .flush_i(flush), .pipe_stall_i(pipe_stall),
    .stall_o(stall), .rdata_o(rdata_q), .rdata_valid_o(rvalid), .bus_err_o(bus_err),
    .data_req_o(req), .data_wr_o(wr), .data_size_o(bsize), .data_wstrb_o(wstrb),
    .data_addr_o(baddr), .data_wdata_o(bwdata), .data_addr_ok_i(addr_ok),
    .data_data_ok_i(data_ok), .data_rdata_i(rdata)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] mw;
    logic [1:0] sz;
    logic [31:0] a, wd, rd;
    logic tog, ewr;
    logic [1:0] esz;
    logic [31:0] ewd;
  } vec_t;
  vec_t tbl[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic clr();
    mem_en = 0; memwrite = 0; size = 0; addr = 0; wdata = 0; flush = 0;
    pipe_stall = 0; addr_ok = 0; data_ok = 0; rdata = 0; rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int reqacc, vseen, rq2, errc, reqbad, pulses;
    logic [31:0] model_rd;
    bit known;
    tbl[0] = '{4'b1111, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 2'd2, 32'hDEAD_BEEF};
    tbl[1] = '{4'b1000, 2'd0, 32'h1000_0003, 32'h0000_00A5, 32'h0, 1'b0, 1'b1, 2'd0, 32'hA5A5_A5A5};
    tbl[2] = '{4'b1100, 2'd1, 32'h1000_0002, 32'h0000_1234, 32'h0, 1'b1, 1'b1, 2'd1, 32'h1234_1234};
    tbl[3] = '{4'b0000, 2'd3, 32'h2000_0008, 32'h0, 32'h1357_9BDF, 1'b0, 1'b0, 2'd2, 32'h0};
    tbl[4] = '{4'b0000, 2'd0, 32'h2000_0001, 32'h1234_5678, 32'h0000_00EE, 1'b1, 1'b0, 2'd0, 32'h7878_7878};
    clr();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", req, 0); chk("rst_stall", stall, 0); chk("rst_valid", rvalid, 0);
    chk("rst_err", bus_err, 0); chk("rst_rdata", rdata_q, 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_en = 1; memwrite = tbl[i].mw; size = tbl[i].sz; addr = tbl[i].a; wdata = tbl[i].wd;
      #1;
      chk("v_launch_stall", stall, 1); chk("v_launch_req", req, 0);
      @(negedge clk);
      mem_en = 0; addr_ok = 1; data_ok = tbl[i].tog; rdata = tbl[i].rd;
      #1;
      chk("v_req", req, 1); chk("v_wr", wr, tbl[i].ewr); chk("v_size", bsize, tbl[i].esz);
      chk("v_wstrb", wstrb, tbl[i].mw); chk("v_addr", baddr, tbl[i].a);
      chk("v_wdata", bwdata, tbl[i].ewd); chk("v_req_stall", stall, 1);
      if (!tbl[i].tog) begin
        @(negedge clk);
        addr_ok = 0; data_ok = 1;
        #1;
        chk("v_wait_req", req, 0); chk("v_wait_stall", stall, 1);
      end
      @(negedge clk);
      addr_ok = 0; data_ok = 0;
      #1;
      chk("v_done_stall", stall, 0); chk("v_done_valid", rvalid, !tbl[i].ewr);
      if (!tbl[i].ewr) chk("v_done_rdata", rdata_q, tbl[i].rd);
      @(negedge clk);
      #1;
      chk("v_idle_valid", rvalid, 0); chk("v_idle_stall", stall, 0);
    end
    clr();
    reqacc = 0;
    memwrite = 0; size = 2; addr = 32'h2000_0010;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      mem_en = c == 0; addr_ok = c == 5; data_ok = c == 8 || c == 10;
      rdata = c == 8 ? 32'hCAFE_F00D : c == 10 ? 32'h0BAD_0BAD : 32'h0;
      pipe_stall = c == 9 || c == 10;
      #1;
      if (req && addr_ok) reqacc++;
      if (c >= 1 && c <= 5) begin
        chk("lw_req_hold", req, 1); chk("lw_addr_hold", baddr, 32'h2000_0010);
      end
      if (c == 6 || c == 7) begin
        chk("lw_wait_req", req, 0); chk("lw_wait_stall", stall, 1);
      end
      if (c >= 9 && c <= 11) begin
        chk("lw_valid", rvalid, 1); chk("lw_rdata", rdata_q, 32'hCAFE_F00D); chk("lw_done_stall", stall, 0);
      end
      if (c == 12) chk("lw_idle_valid", rvalid, 0);
    end
    chk("lw_one_request", reqacc, 1);
    clr();
    vseen = 0; rq2 = 0;
    addr = 32'h3000_0000; size = 2;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      mem_en = c == 0; addr_ok = c == 1; flush = c == 2; data_ok = c == 4; rdata = 32'h7777_7777;
      #1;
      if (rvalid) vseen++;
      if (c >= 2 && req) rq2++;
      if (c == 4) chk("fl_wait_stall", stall, 1);
      if (c == 5) chk("fl_idle_stall", stall, 0);
    end
    chk("fl_no_valid", vseen, 0); chk("fl_no_rereq", rq2, 0);
    @(negedge clk);
    mem_en = 1; flush = 1;
    #1;
    chk("fl_same_stall", stall, 0);
    @(negedge clk);
    mem_en = 0; flush = 0;
    #1;
    chk("fl_same_req", req, 0); chk("fl_same_stall2", stall, 0);
    clr();
    errc = 0; reqbad = 0; pulses = 0;
    addr = 32'h5000_0000; size = 2;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      mem_en = c == 0;
      #1;
      if (bus_err) pulses++;
      if (c >= 1 && c <= 8) begin
        if (bus_err) errc++;
        if (!req) reqbad++;
      end
      if (c == 9) begin
        chk("to_err", bus_err, 1); chk("to_req_drop", req, 0);
      end
      if (c == 10) begin
        chk("to_stall_low", stall, 0); chk("to_req_idle", req, 0);
      end
    end
    chk("to_early_err", errc, 0); chk("to_req_held", reqbad, 0); chk("to_one_pulse", pulses, 1);
    clr();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      mem_en = c == 0; memwrite = 4'hF; size = 2; addr = 32'h4000_0000; wdata = 32'h55AA_55AA;
      addr_ok = c == 1; rst = c == 2; data_ok = c == 3 || c == 4; rdata = 32'h0000_FFFF;
      #1;
      if (c == 3) begin
        chk("rw_req", req, 0); chk("rw_stall", stall, 0); chk("rw_valid", rvalid, 0);
        chk("rw_err", bus_err, 0); chk("rw_rdata", rdata_q, 0); chk("rw_addr", baddr, 0);
        chk("rw_wdata", bwdata, 0); chk("rw_wr", wr, 0); chk("rw_wstrb", wstrb, 0);
      end
      if (c == 4) begin
        chk("rw_late_valid", rvalid, 0); chk("rw_late_rdata", rdata_q, 0); chk("rw_late_stall", stall, 0);
      end
    end
    clr();
    model_rd = 0; known = 1;
    for (int t = 0; t < 40; t++) begin
      int rd_op, es, ad, dd, hold, fc, dcyc, reqc, accc, stc, vc, fbad;
      bit fl, acc;
      logic [31:0] a, wd, rv, ewd;
      logic [3:0] mw;
      logic [1:0] szr;
      rd_op = $urandom_range(0, 1); szr = 2'($urandom_range(0, 3)); a = $urandom; wd = $urandom; rv = $urandom;
      ad = $urandom_range(0, 3); dd = $urandom_range(0, 3); hold = $urandom_range(0, 2);
      fl = (ad + dd > 0) && $urandom_range(0, 3) == 0;
      fc = fl ? $urandom_range(1, ad + dd) : 0;
      es = szr == 2'd3 ? 2 : int'(szr);
      mw = rd_op ? 4'h0 : es == 0 ? 4'b0001 << a[1:0] : es == 1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'hF;
      ewd = es == 0 ? wd[7:0] * 32'h0101_0101 : es == 1 ? wd[15:0] * 32'h0001_0001 : wd;
      dcyc = 1 + ad + dd;
      reqc = 0; accc = -1; stc = 0; vc = 0; fbad = 0; acc = 0;
      memwrite = mw; size = szr; addr = a; wdata = wd;
      for (int c = 0; c <= dcyc + hold + 1 && c < 20; c++) begin
        @(negedge clk);
        mem_en = c == 0; flush = fl && c == fc; pipe_stall = c > dcyc && c <= dcyc + hold;
        #1;
        addr_ok = req && reqc == ad;
        if (addr_ok) begin
          acc = 1; accc = c;
        end
        data_ok = acc && c == accc + dd; rdata = rv;
        if (req) begin
          reqc++;
          if (wr !== !rd_op || bsize !== 2'(es) || wstrb !== mw || baddr !== a || bwdata !== ewd) fbad++;
        end
        #1;
        if (stall) stc++;
        if (rvalid) vc++;
      end
      addr_ok = 0; data_ok = 0; flush = 0; pipe_stall = 0;
      chk("rnd_stall_cycles", stc, 2 + ad + dd);
      chk("rnd_req_cycles", reqc, ad + 1);
      chk("rnd_valid_cycles", vc, (rd_op && !fl) ? hold + 1 : 0);
      chk("rnd_bus_fields", fbad, 0);
      if (rd_op && !fl) chk("rnd_rdata", rdata_q, rv);
      else if (!rd_op && known) chk("rnd_rdata_kept", rdata_q, model_rd);
      if (rd_op && !fl) begin
        model_rd = rv; known = 1;
      end else if (rd_op) known = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
